// File: rtl/uart_rx_if.sv
// Byte-side handshake bundle of the UART receiver.
// master drives data/valid/err/overrun; slave drives ready.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic       rx_frame_err;
  logic       rx_overrun;

  modport master (
    output rx_data,
    output rx_data_valid,
    output rx_frame_err,
    output rx_overrun,
    input  rx_data_ready
  );

  modport slave (
    input  rx_data,
    input  rx_data_valid,
    input  rx_frame_err,
    input  rx_overrun,
    output rx_data_ready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop sync, mid-bit sampling, valid/ready out.
// Ports: clk, rst (sync, high), rx_pin (async serial), rx_if (master).
module uart_rx #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rx_pin,
  uart_rx_if.master rx_if
);
  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int HALF  = CYCLE / 2;
  localparam logic [15:0] CYC_END  = 16'(CYCLE - 1);
  localparam logic [15:0] HALF_END = 16'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_REC_BYTE,
    S_STOP,
    S_DATA,
    S_WAIT_IDLE
  } state_t;

  state_t      state_q, state_d;
  logic        sync_q, sync_d;
  logic        rx_s_q, rx_s_d;
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;

  always_comb begin
    sync_d      = rx_pin;
    rx_s_d      = sync_q;
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    // a held byte drops only once the consumer takes it
    valid_d     = valid_q && !rx_if.rx_data_ready;
    ferr_d      = 1'b0;
    ovr_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cycle_cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cycle_cnt_q == HALF_END) begin
          cycle_cnt_d = '0;
          bit_cnt_d   = '0;
          state_d     = rx_s_q ? S_IDLE : S_REC_BYTE;
        end else begin
          cycle_cnt_d = cycle_cnt_q + 16'd1;
        end
      end
      S_REC_BYTE: begin
        if (cycle_cnt_q == CYC_END) begin
          cycle_cnt_d        = '0;
          shift_d[bit_cnt_q] = rx_s_q;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end else begin
          cycle_cnt_d = cycle_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (cycle_cnt_q == CYC_END) begin
          cycle_cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_DATA;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          cycle_cnt_d = cycle_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        // new byte wins over a simultaneous accept
        data_d  = shift_q;
        valid_d = 1'b1;
        ovr_d   = valid_q && !rx_if.rx_data_ready;
        state_d = S_IDLE;
      end
      S_WAIT_IDLE: begin
        // a break must not turn into a stream of bogus frames
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      cycle_cnt_q <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      rx_s_q      <= rx_s_d;
      cycle_cnt_q <= cycle_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
    end
  end

  assign rx_if.rx_data       = data_q;
  assign rx_if.rx_data_valid = valid_q;
  assign rx_if.rx_frame_err  = ferr_q;
  assign rx_if.rx_overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at CYCLE=10: vector table plus corner sequences.
// Counts valid/error/overrun cycles at negedge and compares.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst;
  logic rx_pin;

  uart_rx_if bus ();

  uart_rx #(.CLK_FRE(50), .BAUD_RATE(5000000)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_pin(rx_pin),
    .rx_if (bus.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   v_cnt = 0;
  int   e_cnt = 0;
  int   o_cnt = 0;
  int   rise_cyc = 0;
  logic v_prev = 1'b0;
  logic [7:0] got [$];

  always @(negedge clk) begin
    if (bus.rx_data_valid) v_cnt++;
    if (bus.rx_frame_err) e_cnt++;
    if (bus.rx_overrun) o_cnt++;
    if (bus.rx_data_valid && !v_prev) begin
      rise_cyc = cyc;
      got.push_back(bus.rx_data);
    end
    v_prev = bus.rx_data_valid;
  end

  int checks = 0;
  int errors = 0;
  int bv, be, bo, bg;
  int start_cyc;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    bv = v_cnt;
    be = e_cnt;
    bo = o_cnt;
    bg = got.size();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stp);
    start_cyc = cyc;
    rx_pin = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      tick(10);
    end
    rx_pin = stp;
    tick(10);
  endtask

  typedef struct {
    bit         glitch;
    logic [7:0] data;
    logic       stp;
    int         hold_low;
    int         exp_v;
    int         exp_e;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vt [4];

  initial begin
    vt[0] = '{1'b0, 8'hA5, 1'b1, 0,  1, 0, 8'hA5};
    vt[1] = '{1'b1, 8'h00, 1'b1, 0,  0, 0, 8'h00};
    vt[2] = '{1'b0, 8'h3C, 1'b0, 50, 0, 1, 8'h00};
    vt[3] = '{1'b0, 8'h55, 1'b1, 0,  1, 0, 8'h55};

    rst = 1'b1;
    rx_pin = 1'b1;
    bus.rx_data_ready = 1'b1;
    tick(3);
    chk("rst_data", int'(bus.rx_data), 0);
    chk("rst_valid", int'(bus.rx_data_valid), 0);
    chk("rst_ferr", int'(bus.rx_frame_err), 0);
    chk("rst_ovr", int'(bus.rx_overrun), 0);
    rst = 1'b0;
    tick(5);

    for (int k = 0; k < 4; k++) begin
      snap();
      if (vt[k].glitch) begin
        rx_pin = 1'b0;
        tick(3);
        rx_pin = 1'b1;
      end else begin
        send_frame(vt[k].data, vt[k].stp);
        if (vt[k].hold_low > 0) begin
          rx_pin = 1'b0;
          tick(vt[k].hold_low);
          rx_pin = 1'b1;
        end
      end
      tick(20);
      chk($sformatf("v%0d_valid_cycles", k), v_cnt - bv, vt[k].exp_v);
      chk($sformatf("v%0d_ferr", k), e_cnt - be, vt[k].exp_e);
      chk($sformatf("v%0d_ovr", k), o_cnt - bo, 0);
      if (vt[k].exp_v > 0 && got.size() > bg)
        chk($sformatf("v%0d_data", k), int'(got[bg]), int'(vt[k].exp_d));
      if (k == 0) begin
        chk("latency_ok",
            int'((rise_cyc - start_cyc) >= 98 && (rise_cyc - start_cyc) <= 100), 1);
      end
    end

    snap();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(20);
    chk("b2b_count", got.size() - bg, 2);
    if (got.size() >= bg + 2) begin
      chk("b2b_first", int'(got[bg]), 8'h00);
      chk("b2b_second", int'(got[bg+1]), 8'hFF);
    end
    chk("b2b_ovr", o_cnt - bo, 0);
    chk("b2b_ferr", e_cnt - be, 0);

    snap();
    bus.rx_data_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    tick(5);
    send_frame(8'h22, 1'b1);
    tick(10);
    chk("ovr_data", int'(bus.rx_data), 8'h22);
    chk("ovr_valid", int'(bus.rx_data_valid), 1);
    chk("ovr_pulses", o_cnt - bo, 1);
    bus.rx_data_ready = 1'b1;
    tick(1);
    chk("ovr_cleared", int'(bus.rx_data_valid), 0);

    bus.rx_data_ready = 1'b0;
    send_frame(8'h33, 1'b1);
    tick(5);
    chk("pre_rst_valid", int'(bus.rx_data_valid), 1);
    snap();
    rx_pin = 1'b0;
    tick(10);
    for (int i = 0; i < 4; i++) begin
      rx_pin = 1'(8'h5A >> i);
      tick(10);
    end
    rx_pin = 1'(8'h5A >> 4);
    tick(5);
    rst = 1'b1;
    rx_pin = 1'b1;
    tick(2);
    chk("midrst_data", int'(bus.rx_data), 0);
    chk("midrst_valid", int'(bus.rx_data_valid), 0);
    chk("midrst_ferr", int'(bus.rx_frame_err), 0);
    chk("midrst_ovr", int'(bus.rx_overrun), 0);
    rst = 1'b0;
    bus.rx_data_ready = 1'b1;
    tick(30);
    chk("postrst_none", got.size() - bg, 0);
    send_frame(8'h81, 1'b1);
    tick(20);
    chk("postrst_count", got.size() - bg, 1);
    if (got.size() > bg)
      chk("postrst_data", int'(got[bg]), 8'h81);
    chk("postrst_ferr", e_cnt - be, 0);
    chk("postrst_ovr", o_cnt - bo, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
